// File: rtl/stream_byte_aligner_if.sv
// rtl/stream_byte_aligner_if.sv - input and output beat handshake bundle for stream_byte_aligner
interface stream_byte_aligner_if #(
  parameter int BYTES  = 16,
  parameter int BYTE_W = 8,
  parameter int OFF_W  = $clog2(BYTES),
  parameter int CNT_W  = $clog2(BYTES + 1)
);
  logic                    s_valid;
  logic                    s_ready;
  logic [BYTES*BYTE_W-1:0] s_data;
  logic                    s_first;
  logic                    s_last;
  logic                    s_mode;
  logic [OFF_W-1:0]        s_offset;
  logic [CNT_W-1:0]        s_bytes;
  logic                    m_valid;
  logic                    m_ready;
  logic [BYTES*BYTE_W-1:0] m_data;
  logic                    m_last;
  logic [CNT_W-1:0]        m_bytes;
  logic                    err;

  modport slave (
    input  s_valid, s_data, s_first, s_last, s_mode, s_offset, s_bytes, m_ready,
    output s_ready, m_valid, m_data, m_last, m_bytes, err
  );

  modport master (
    output s_valid, s_data, s_first, s_last, s_mode, s_offset, s_bytes, m_ready,
    input  s_ready, m_valid, m_data, m_last, m_bytes, err
  );
endinterface

// File: rtl/stream_byte_aligner.sv
// rtl/stream_byte_aligner.sv - registered byte-lane realigner (per-beat rotate or multi-beat offset strip)
module stream_byte_aligner #(
  parameter int BYTES  = 16,
  parameter int BYTE_W = 8,
  parameter int OFF_W  = $clog2(BYTES),
  parameter int CNT_W  = $clog2(BYTES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  stream_byte_aligner_if.slave bus
);
  localparam int DW = BYTES * BYTE_W;
  localparam logic [CNT_W-1:0] FULL   = CNT_W'(BYTES);
  localparam logic [CNT_W:0]   FULL_A = (CNT_W + 1)'(BYTES);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t           state, state_nxt;
  logic [DW-1:0]    hold, hold_nxt;
  logic             mode_r, mode_nxt;
  logic [OFF_W-1:0] off_r, off_nxt;
  logic [CNT_W-1:0] last_bytes_r, last_bytes_nxt;

  logic             m_valid_r, m_last_r, err_r;
  logic [DW-1:0]    m_data_r;
  logic [CNT_W-1:0] m_bytes_r;

  logic             out_load, accept, start, mode_e;
  logic [OFF_W-1:0] off_e;
  logic [CNT_W:0]   a_cnt;
  logic             out_vld, out_last, err_nxt;
  logic [DW-1:0]    out_raw;
  logic [CNT_W-1:0] out_bytes;

  // Lanes off..off+BYTES-1 of {hi, lo}; covers rotate, stitch and residual shift.
  function automatic logic [DW-1:0] funnel(input logic [DW-1:0] hi, input logic [DW-1:0] lo,
                                           input logic [OFF_W-1:0] off);
    logic [2*DW-1:0] cat;
    cat = {hi, lo} >> (int'(off) * BYTE_W);
    return cat[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] lane_mask(input logic [DW-1:0] d, input logic [CNT_W-1:0] n);
    logic [DW-1:0] r;
    r = '0;
    for (int j = 0; j < BYTES; j++) begin
      if (j < int'(n)) r[j*BYTE_W +: BYTE_W] = d[j*BYTE_W +: BYTE_W];
    end
    return r;
  endfunction

  assign out_load    = !m_valid_r || bus.m_ready;
  assign bus.s_ready = (state != FLUSH) && out_load;
  assign accept      = bus.s_valid && bus.s_ready;
  assign start       = (state == IDLE) || bus.s_first;
  assign mode_e      = start ? bus.s_mode : mode_r;
  assign off_e       = start ? bus.s_offset : off_r;
  assign a_cnt       = FULL_A - (CNT_W + 1)'(off_e) + (CNT_W + 1)'(bus.s_bytes);

  always_comb begin
    state_nxt      = state;
    hold_nxt       = hold;
    mode_nxt       = mode_r;
    off_nxt        = off_r;
    last_bytes_nxt = last_bytes_r;
    out_vld        = 1'b0;
    out_raw        = '0;
    out_bytes      = FULL;
    out_last       = 1'b0;
    err_nxt        = 1'b0;

    if (state == FLUSH) begin
      if (out_load) begin
        out_vld   = 1'b1;
        out_raw   = funnel('0, hold, off_r);
        out_bytes = last_bytes_r - CNT_W'(off_r);
        out_last  = 1'b1;
        state_nxt = IDLE;
      end
    end else if (accept) begin
      mode_nxt  = mode_e;
      off_nxt   = off_e;
      err_nxt   = (state == RUN) && bus.s_first;
      state_nxt = bus.s_last ? IDLE : RUN;
      if (!mode_e) begin
        out_vld  = 1'b1;
        out_raw  = funnel(bus.s_data, bus.s_data, bus.s_offset);
        out_last = bus.s_last;
      end else if (off_e == '0) begin
        out_vld  = 1'b1;
        out_raw  = bus.s_data;
        out_last = bus.s_last;
        if (bus.s_last) out_bytes = bus.s_bytes;
      end else if (start) begin
        hold_nxt = bus.s_data;
        if (bus.s_last) begin
          // A lone beat shorter than the offset carries no payload at all.
          if (bus.s_bytes > CNT_W'(off_e)) begin
            out_vld   = 1'b1;
            out_raw   = funnel('0, bus.s_data, off_e);
            out_bytes = bus.s_bytes - CNT_W'(off_e);
            out_last  = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end else begin
        hold_nxt = bus.s_data;
        out_vld  = 1'b1;
        out_raw  = funnel(bus.s_data, hold, off_e);
        if (bus.s_last) begin
          if (a_cnt <= FULL_A) begin
            out_bytes = a_cnt[CNT_W-1:0];
            out_last  = 1'b1;
          end else begin
            last_bytes_nxt = bus.s_bytes;
            state_nxt      = FLUSH;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      hold         <= '0;
      mode_r       <= 1'b0;
      off_r        <= '0;
      last_bytes_r <= '0;
      m_valid_r    <= 1'b0;
      m_data_r     <= '0;
      m_last_r     <= 1'b0;
      m_bytes_r    <= '0;
      err_r        <= 1'b0;
    end else begin
      state        <= state_nxt;
      hold         <= hold_nxt;
      mode_r       <= mode_nxt;
      off_r        <= off_nxt;
      last_bytes_r <= last_bytes_nxt;
      err_r        <= err_nxt;
      if (out_load) begin
        m_valid_r <= out_vld;
        if (out_vld) begin
          m_data_r  <= lane_mask(out_raw, out_bytes);
          m_last_r  <= out_last;
          m_bytes_r <= out_bytes;
        end
      end
    end
  end

  assign bus.m_valid = m_valid_r;
  assign bus.m_data  = m_data_r;
  assign bus.m_last  = m_last_r;
  assign bus.m_bytes = m_bytes_r;
  assign bus.err     = err_r;
endmodule

// File: tb/tb_stream_byte_aligner.sv
// tb/tb_stream_byte_aligner.sv - table-driven scoreboard bench for stream_byte_aligner
module tb_stream_byte_aligner;
  localparam int BYTES = 16;
  localparam int DW    = BYTES * 8;
  localparam int NV    = 12;

  typedef struct {
    logic data_unused;
  } dummy_t;

  typedef struct {
    logic mode;
    int   off;
    int   nbeats;
    int   lbytes;
    int   nout;
    int   nerr;
    bit   bp;
    bit   fl;
    bit   inc;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    int            bytes;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stream_byte_aligner_if #(.BYTES(BYTES), .BYTE_W(8)) bus ();
  stream_byte_aligner #(.BYTES(BYTES), .BYTE_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int out_cnt = 0;
  int err_cnt = 0;
  bit mon_en = 1'b0;
  bit bp_en = 1'b0;
  exp_t exp_q[$];
  logic [DW-1:0] beats[8];
  vec_t vt[NV];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic gen_beats(input int n, input bit inc);
    for (int b = 0; b < n; b++)
      for (int j = 0; j < BYTES; j++)
        beats[b][j*8 +: 8] = inc ? 8'(b * BYTES + j) : 8'($urandom);
  endtask

  // Byte-stream model: ALIGN concatenates valid bytes, drops off, re-chunks.
  task automatic model_push(input logic md, input int off, input int n, input int lb, input bit trunc);
    logic [7:0] s[$];
    exp_t e;
    if (!md) begin
      for (int b = 0; b < n; b++) begin
        e.data = '0;
        for (int j = 0; j < BYTES; j++) e.data[j*8 +: 8] = beats[b][((j + off) % BYTES)*8 +: 8];
        e.bytes = BYTES;
        e.last  = (b == n - 1) && !trunc;
        exp_q.push_back(e);
      end
    end else begin
      for (int b = 0; b < n; b++)
        for (int i = 0; i < ((b == n - 1 && !trunc) ? lb : BYTES); i++) s.push_back(beats[b][i*8 +: 8]);
      for (int i = 0; i < off && s.size() > 0; i++) void'(s.pop_front());
      while (s.size() > 0 && !(trunc && s.size() < BYTES)) begin
        e.data  = '0;
        e.bytes = 0;
        while (e.bytes < BYTES && s.size() > 0) begin
          e.data[e.bytes*8 +: 8] = s.pop_front();
          e.bytes++;
        end
        e.last = !trunc && (s.size() == 0);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic f, input logic l, input logic md,
                      input int off, input int nb);
    int t;
    bus.s_data   = d;
    bus.s_first  = f;
    bus.s_last   = l;
    bus.s_mode   = md;
    bus.s_offset = 4'(off);
    bus.s_bytes  = 5'(nb);
    bus.s_valid  = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bus.s_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.s_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=s_ready_low expected=accept");
    end
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic drive_pkt(input logic md, input int off, input int n, input int lb, input bit fl);
    for (int b = 0; b < n; b++) send(beats[b], b == 0, b == n - 1, md, off, (b == n - 1) ? lb : BYTES);
    if (fl) begin
      @(negedge clk);
      chk("flush_s_ready", DW'(bus.s_ready), DW'(0));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d_pending expected=0", exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] pat;
    int bp_i;
    pat  = 4'b1001;
    bp_i = 0;
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) begin
        bus.m_ready = pat[bp_i % 4];
        bp_i++;
      end else begin
        bus.m_ready = 1'b1;
      end
    end
  end

  initial begin
    exp_t e;
    bit stall_prev;
    logic [DW-1:0] snap_data;
    logic [4:0] snap_bytes;
    logic snap_last;
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !mon_en) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("stall_valid", DW'(bus.m_valid), DW'(1));
          chk("stall_data", bus.m_data, snap_data);
          chk("stall_bytes", DW'(bus.m_bytes), DW'(snap_bytes));
          chk("stall_last", DW'(bus.m_last), DW'(snap_last));
        end
        if (bus.m_valid && !bus.m_ready) chk("stall_s_ready", DW'(bus.s_ready), DW'(0));
        if (bus.m_valid && bus.m_ready) begin
          out_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output actual=%0h expected=none", bus.m_data);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", bus.m_data, e.data);
            chk("out_bytes", DW'(bus.m_bytes), DW'(e.bytes));
            chk("out_last", DW'(bus.m_last), DW'(e.last));
          end
        end
        if (bus.err) err_cnt++;
        stall_prev = bus.m_valid && !bus.m_ready;
        snap_data  = bus.m_data;
        snap_bytes = bus.m_bytes;
        snap_last  = bus.m_last;
      end
    end
  end

  initial begin
    int o0;
    int e0;
    vt[0]  = '{1'b0, 5,  1, 16, 1, 0, 1'b0, 1'b0, 1'b1};
    vt[1]  = '{1'b1, 3,  3, 16, 3, 0, 1'b0, 1'b1, 1'b1};
    vt[2]  = '{1'b1, 3,  2, 2,  1, 0, 1'b0, 1'b0, 1'b1};
    vt[3]  = '{1'b1, 3,  3, 16, 3, 0, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 4,  1, 4,  0, 1, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 0,  2, 7,  2, 0, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 0,  3, 16, 3, 0, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 15, 1, 16, 1, 0, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 15, 2, 16, 2, 0, 1'b0, 1'b1, 1'b0};
    vt[9]  = '{1'b0, 11, 2, 16, 2, 0, 1'b1, 1'b0, 1'b0};
    vt[10] = '{1'b1, 1,  4, 1,  3, 0, 1'b1, 1'b0, 1'b0};
    vt[11] = '{1'b1, 8,  2, 8,  1, 0, 1'b0, 1'b0, 1'b0};

    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_first = 1'b0; bus.s_last = 1'b0;
    bus.s_mode = 1'b0; bus.s_offset = '0; bus.s_bytes = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", DW'(bus.m_valid), DW'(0));
    chk("rst_m_data", bus.m_data, DW'(0));
    chk("rst_m_last", DW'(bus.m_last), DW'(0));
    chk("rst_m_bytes", DW'(bus.m_bytes), DW'(0));
    chk("rst_err", DW'(bus.err), DW'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_s_ready", DW'(bus.s_ready), DW'(1));
    mon_en = 1'b1;

    for (int v = 0; v < NV; v++) begin
      gen_beats(vt[v].nbeats, vt[v].inc);
      o0 = out_cnt;
      e0 = err_cnt;
      model_push(vt[v].mode, vt[v].off, vt[v].nbeats, vt[v].lbytes, 1'b0);
      bp_en = vt[v].bp;
      drive_pkt(vt[v].mode, vt[v].off, vt[v].nbeats, vt[v].lbytes, vt[v].fl);
      drain();
      bp_en = 1'b0;
      chk($sformatf("vec%0d_nout", v), DW'(out_cnt - o0), DW'(vt[v].nout));
      chk($sformatf("vec%0d_nerr", v), DW'(err_cnt - e0), DW'(vt[v].nerr));
    end

    // s_first in mid-packet: residual of the abandoned packet is dropped.
    o0 = out_cnt;
    e0 = err_cnt;
    gen_beats(2, 1'b0);
    model_push(1'b1, 3, 2, 16, 1'b1);
    send(beats[0], 1'b1, 1'b0, 1'b1, 3, 16);
    send(beats[1], 1'b0, 1'b0, 1'b1, 3, 16);
    gen_beats(2, 1'b0);
    model_push(1'b1, 2, 2, 5, 1'b0);
    drive_pkt(1'b1, 2, 2, 5, 1'b0);
    drain();
    chk("restart_nout", DW'(out_cnt - o0), DW'(3));
    chk("restart_nerr", DW'(err_cnt - e0), DW'(1));

    // Reset asserted while the residual beat is pending.
    mon_en = 1'b0;
    gen_beats(3, 1'b0);
    drive_pkt(1'b1, 3, 3, 16, 1'b0);
    chk("pre_rst_flush_s_ready", DW'(bus.s_ready), DW'(0));
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_m_valid", DW'(bus.m_valid), DW'(0));
    chk("mid_rst_m_data", bus.m_data, DW'(0));
    chk("mid_rst_m_last", DW'(bus.m_last), DW'(0));
    chk("mid_rst_m_bytes", DW'(bus.m_bytes), DW'(0));
    chk("mid_rst_err", DW'(bus.err), DW'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_s_ready", DW'(bus.s_ready), DW'(1));
    mon_en = 1'b1;
    o0 = out_cnt;
    gen_beats(2, 1'b1);
    model_push(1'b1, 3, 2, 2, 1'b0);
    drive_pkt(1'b1, 3, 2, 2, 1'b0);
    drain();
    chk("post_rst_nout", DW'(out_cnt - o0), DW'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stream_byte_aligner.md
# stream_byte_aligner

Parametrised, registered byte-lane realigner for the datapath byte streams. Per packet it runs in one of two modes:
- **ROTATE:** rotates each beat independently by a per-beat byte offset.
- **ALIGN:** strips a leading byte offset from a multi-beat packet, stitching bytes across beat boundaries and emitting a trailing flush beat when needed.

It sits between packet-buffer read ports and consumers that need lane-0-aligned data. It has valid/ready handshakes on both sides and one output register stage.

## Interface
- BYTES, 16: lanes per beat; power of two, ≥2.
- BYTE_W, 8: bits per lane.
- OFF_W, clog2(BYTES): offset width.
- CNT_W, clog2(BYTES+1): byte-count width.

- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid && s_ready.
- s_data  in  BYTES*BYTE_W  input beat; lane j = bits [j*BYTE_W +: BYTE_W].
- s_first  in  1  first beat of packet.
- s_last  in  1  last beat of packet.
- s_mode  in  1  0 = ROTATE, 1 = ALIGN; sampled on first beat, held for the packet.
- s_offset  in  OFF_W  ROTATE: used on every beat. ALIGN: sampled on first beat only.
- s_bytes  in  CNT_W  valid bytes in a last beat, 1..BYTES (lanes 0..s_bytes-1); ignored otherwise.
- m_valid  out  1  output beat valid.
- m_ready  in  1  output accepted when m_valid && m_ready.
- m_data  out  BYTES*BYTE_W  output beat; lanes ≥ m_bytes are zero.
- m_last  out  1  last output beat of packet.
- m_bytes  out  CNT_W  valid lanes in m_data, 1..BYTES.
- err  out  1  one-cycle protocol-error pulse.

## Operation
**States:** IDLE (no packet), RUN (mid-packet, hold register may be valid), FLUSH (residual pending, input stalled).
- **Packet start.** A beat accepted in IDLE always starts a packet, even with s_first=0. A beat with s_first accepted in RUN also starts a packet: the hold register is discarded and err pulses.
- **ROTATE.** Output lane j = input lane (j+s_offset) mod BYTES, the same rule on every beat. m_bytes=BYTES; m_last=s_last. State is IDLE after the last beat, RUN otherwise.
- **ALIGN, off=0.** Pass-through. m_bytes = BYTES, or s_bytes on the last beat.
- **ALIGN, off>0, first beat.** Store the beat in hold; no output.
  - If the first beat is also last and s_bytes>off: output lanes off..s_bytes-1 moved down to lane 0, m_bytes=s_bytes-off, m_last=1.
  - If s_bytes≤off: no output, err pulses, return to IDLE.
- **ALIGN, off>0, later beat.** Output lane j = hold lane off+j for j<BYTES-off, else new lane j-(BYTES-off). Store the new beat in hold.
  - Not last: m_bytes=BYTES, m_last=0.
  - Last with A=(BYTES-off)+s_bytes ≤ BYTES: m_bytes=A, m_last=1, go to IDLE.
  - Last with A>BYTES: m_bytes=BYTES, m_last=0, go to FLUSH.
- **FLUSH.** Emit hold lanes off..s_bytes-1 moved down to lane 0, m_bytes=s_bytes-off, m_last=1, then go to IDLE. The s_bytes value used here is the one registered at the last beat.
- **Widths.** All lane indices are taken mod BYTES. A is computed in CNT_W+1 bits.

## Timing
- **Reset values.** m_valid=0, m_data=0, m_last=0, m_bytes=0, err=0; state=IDLE; hold cleared. s_ready reads 1 once reset deasserts.
- **Ready.** s_ready = (state≠FLUSH) && (!m_valid || m_ready), a combinational function of registered state and m_ready.
- **Latency.** One cycle from accepted beat to m_valid. The exception is the ALIGN off>0 first beat, which produces no output until the next accepted beat.
- **Throughput.** One beat per cycle under continuous m_ready. FLUSH costs exactly one extra output cycle, with s_ready=0 during it.
- **Backpressure.** With m_valid=1 and m_ready=0, m_* holds stable and no input is accepted.
- **Reset mid-packet.** Asynchronously returns everything to the reset values; the in-flight beat and the residual are lost.
- **err.** Registered; asserts in the cycle after the offending acceptance.

## Test plan
- **ROTATE.** BYTES=16, lane i=i, offset 5, single beat first+last → one cycle later m_data lanes 5,6,…,15,0,…,4; m_bytes=16; m_last=1.
- **ALIGN with flush.** off=3, 3 beats (last s_bytes=16), m_ready=1 → outputs of 16, 16, 13 bytes; the third has m_last=1; s_ready=0 during the FLUSH cycle.
- **ALIGN, no flush.** off=3, 2 beats (last s_bytes=2) → one output, m_bytes=15, m_last=1, bytes = beat0 lanes 3..15 then beat1 lanes 0..1.
- **Backpressure.** Same stream as the flush case with m_ready toggling 1,0,0,1 → outputs unchanged while stalled; no beat dropped or duplicated.
- **Errors.** First+last beat with off=4, s_bytes=4 → no output, err=1 for one cycle. s_first arriving mid-packet → residual dropped, err pulses, new packet output correct.
- **Reset.** Assert rst during FLUSH → all outputs 0 immediately; next packet after release processed correctly.
